// File: rtl/button_poller.sv
// button_poller: scans a 4-button peripheral, debounces each bit and queues press/release events.
// Optional BUTTON_POLLER_IRQ_EN adds an irq output that lags evt_valid by one cycle.
module button_poller #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] dev_address,
    output logic       dev_enable,
    output logic       dev_mode,
    input  logic [7:0] dev_data,
    output logic       evt_valid,
    output logic [7:0] evt_data,
    input  logic       evt_pop,
    output logic [3:0] stable,
    output logic       overflow,
    input  logic       clear_overflow
`ifdef BUTTON_POLLER_IRQ_EN
    ,
    output logic       irq
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;
    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    stable_q, stable_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, full, wr_en, drop, sample;
    logic [7:0]    push_data;
    logic          unused_data;

    assign unused_data = ^dev_data[7:1];
    assign sample      = dev_data[0];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        if (state_q == IDLE) begin
            div_d = (div_q == DW'(SCAN_DIV - 1)) ? '0 : div_q + DW'(1);
            state_d = (div_q == DW'(SCAN_DIV - 1)) ? SCAN : IDLE;
            idx_d = 2'd0;
        end else begin
            idx_d   = idx_q + 2'd1;
            state_d = (idx_q == 2'd3) ? IDLE : SCAN;
        end
    end

    // Only the button addressed this cycle can change, so at most one push per cycle.
    always_comb begin
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        push      = 1'b0;
        push_data = 8'h00;
        if (state_q == SCAN) begin
            if (sample == stable_q[idx_q]) begin
                cnt_d[idx_q] = '0;
            end else if (cnt_q[idx_q] == CW'(DEBOUNCE_TICKS - 1)) begin
                cnt_d[idx_q]    = '0;
                stable_d[idx_q] = sample;
                push            = 1'b1;
                push_data       = {sample, 5'b0, idx_q};
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
            end
        end
    end

    always_comb begin
        full    = (count_q == OW'(FIFO_DEPTH));
        pop     = evt_pop && (count_q != '0);
        wr_en   = push && (!full || pop);
        drop    = push && full && !pop;
        wr_d    = wr_q + AW'(wr_en);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + OW'(wr_en) - OW'(pop);
        ovf_d   = drop | (ovf_q & ~clear_overflow);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            idx_q    <= 2'd0;
            cnt_q    <= '{default: '0};
            stable_q <= 4'd0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= push_data;
    end

    assign dev_enable  = (state_q == SCAN);
    assign dev_mode    = (state_q == SCAN);
    assign dev_address = (state_q == SCAN) ? {2'b00, idx_q} : 4'd0;
    assign evt_valid   = (count_q != '0);
    assign evt_data    = evt_valid ? mem_q[rd_q] : 8'h00;
    assign stable      = stable_q;
    assign overflow    = ovf_q;

`ifdef BUTTON_POLLER_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else irq_q <= evt_valid;
    end
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_button_poller.sv
// tb_button_poller: randomized button stimulus against a round-based queue model of the poller.
module tb_button_poller;
    localparam int D = 16;
    localparam int T = 4;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dev_address;
    logic       dev_enable, dev_mode;
    logic [7:0] dev_data = 8'h00;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_pop = 1'b0;
    logic [3:0] stable;
    logic       overflow;
    logic       clear_overflow = 1'b0;
`ifdef BUTTON_POLLER_IRQ_EN
    logic       irq;
`endif

    button_poller #(.SCAN_DIV(D), .DEBOUNCE_TICKS(T), .FIFO_DEPTH(N)) dut (
        .clk(clk),
        .reset(reset),
        .dev_address(dev_address),
        .dev_enable(dev_enable),
        .dev_mode(dev_mode),
        .dev_data(dev_data),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .evt_pop(evt_pop),
        .stable(stable),
        .overflow(overflow),
        .clear_overflow(clear_overflow)
`ifdef BUTTON_POLLER_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    logic [3:0] btn = 4'd0;
    int         cyc = 0;
    int         ncmp = 0;
    int         nbad = 0;
    int         cnt [4] = '{default: 0};
    int         si;
    logic [3:0] stab_e = 4'd0;
    logic       ovf_e = 1'b0;
    logic       irq_e = 1'b0;
    logic       ev_push;
    logic [7:0] ev;
    logic [7:0] q [$];

    function automatic bit is_scan(input int c);
        return c >= D && (c - D) % (D + 4) < 4;
    endfunction

    // Peripheral model: latches the addressed button on the falling edge of a read cycle.
    always @(negedge clk) dev_data = dev_enable ? {7'b0, btn[dev_address[1:0]]} : 8'h00;

    // Reference model: the scan schedule is a pure function of the cycle number since reset.
    always @(posedge clk) begin
        if (reset) begin
            cyc = 0;
            cnt = '{default: 0};
            stab_e = 4'd0;
            ovf_e = 1'b0;
            irq_e = 1'b0;
            q.delete();
        end else begin
            irq_e = (q.size() != 0);
            ev_push = 1'b0;
            if (is_scan(cyc)) begin
                si = (cyc - D) % (D + 4);
                if (btn[si] == stab_e[si]) cnt[si] = 0;
                else begin
                    cnt[si]++;
                    if (cnt[si] == T) begin
                        stab_e[si] = btn[si];
                        cnt[si] = 0;
                        ev_push = 1'b1;
                        ev = {btn[si], 5'b0, 2'(si)};
                    end
                end
            end
            if (evt_pop && q.size() > 0) void'(q.pop_front());
            if (clear_overflow) ovf_e = 1'b0;
            if (ev_push) begin
                if (q.size() < N) q.push_back(ev);
                else ovf_e = 1'b1;
            end
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        chk("dev_enable", 8'(dev_enable), 8'(is_scan(cyc)));
        chk("dev_mode", 8'(dev_mode), 8'(is_scan(cyc)));
        chk("dev_address", 8'(dev_address), is_scan(cyc) ? 8'((cyc - D) % (D + 4)) : 8'h00);
        chk("evt_valid", 8'(evt_valid), 8'(q.size() != 0));
        chk("evt_data", evt_data, (q.size() != 0) ? q[0] : 8'h00);
        chk("stable", 8'(stable), 8'(stab_e));
        chk("overflow", 8'(overflow), 8'(ovf_e));
`ifdef BUTTON_POLLER_IRQ_EN
        chk("irq", 8'(irq), 8'(irq_e));
`endif
    end

    task automatic tick(input bit p, input int clr_pct);
        @(posedge clk);
        #2;
        evt_pop = p;
        clear_overflow = ($urandom_range(99) < clr_pct);
    endtask

    // One full scan round; pop_scan pops exactly during the four SCAN cycles.
    task automatic round(input logic [3:0] b, input int pop_pct, input int clr_pct, input bit pop_scan);
        for (int i = 0; i < D + 4; i++) begin
            tick(pop_scan ? (i >= D - 1 && i <= D + 2) : ($urandom_range(99) < pop_pct), clr_pct);
            if (i == 0) btn = b;
        end
    endtask

    task automatic reset_mid();
        int k = 0;
        while (!(is_scan(cyc) && (cyc - D) % (D + 4) == 2) && k < 100) begin
            tick(1'b0, 0);
            k++;
        end
        if (k == 100) begin
            nbad++;
            $display("FAIL reset_mid: scan idx 2 not reached, got %0d expected <100 cycles", k);
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] b;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (5) round(4'b0100, 0, 0, 0);
        repeat (5) round(4'b0000, 0, 0, 0);
        repeat (2) round(4'b0000, 100, 0, 0);
        repeat (3) round(4'b0010, 0, 0, 0);
        repeat (3) round(4'b0000, 0, 0, 0);
        repeat (4) round(4'b1111, 0, 0, 0);
        repeat (4) round(4'b0000, 0, 0, 0);
        repeat (3) round(4'b1111, 0, 0, 0);
        round(4'b1111, 0, 0, 1);
        round(4'b1111, 0, 100, 0);
        round(4'b1111, 100, 0, 0);
        b = btn;
        repeat (60) begin
            if ($urandom_range(1) == 1) b = b ^ (4'd1 << $urandom_range(3));
            if ($urandom_range(9) == 0) b = 4'($urandom);
            round(b, 30, 3, 0);
        end
        reset_mid();
        repeat (5) round(4'b1001, 20, 0, 0);
        repeat (2) round(4'b1001, 100, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
